mul_seq_ctrl: RTL and testbench

- Multi-cycle 16x16 multiply sequencer that reuses the shared 16-bit arithmetic block (CLA add/OR/XOR/AND, Cin, sign, Ofl) as its adder.
- Runs one shift-add step per cycle, signed or unsigned, and produces a 32-bit product.
- Sits beside the execute stage. Owns the ALU inputs while busy; the core datapath owns them when `alu_grant`=0.

---
 rtl/mul_seq_ctrl.sv | 116 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle WIDTHxWIDTH shift-add multiply sequencer.
// It borrows the shared arithmetic block as its adder. The block does one
// add step per cycle for WIDTH cycles, then holds a 2*WIDTH-bit product.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start             request, accepted only while ready=1
//   is_signed         1 = two's-complement operands (sampled with start)
//   mcand, mplier     operands (sampled with start)
//   ready             idle, can accept start
//   done              one-cycle pulse, product valid from this cycle
//   product           registered result, held until the next multiply ends
//   alu_grant         1 = this block drives the shared ALU inputs
//   alu_A/B/Cin/sign  ALU operand drive (all zero when not granted)
//   alu_op            ALU op, always add
//   alu_out, alu_ofl  ALU sum and overflow/carry flag
module mul_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               alu_grant,
  output logic [WIDTH-1:0]   alu_A,
  output logic [WIDTH-1:0]   alu_B,
  output logic               alu_Cin,
  output logic               alu_sign,
  output logic [1:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_ofl
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   p_hi, p_lo, m;
  logic               s;

  logic               run, last, sub;
  logic               x;
  logic [WIDTH-1:0]   h;
  logic [2*WIDTH-1:0] p_nxt;

  assign run  = (state == RUN);
  assign last = (cnt == CNT_W'(WIDTH-1));
  // The multiplier MSB has negative weight in signed mode, so the final
  // step subtracts the multiplicand (A + ~M + 1).
  assign sub  = s & last;

  assign ready     = (state == IDLE);
  assign done      = (state == DONE);
  assign alu_grant = run;
  assign alu_A     = run ? p_hi : '0;
  assign alu_B     = run ? (sub ? ~m : m) : '0;
  assign alu_Cin   = run & sub;
  assign alu_sign  = run & s;
  assign alu_op    = 2'b00;

  // X is bit WIDTH of the partial sum and is shifted into the top of P_hi.
  // Unsigned: the carry-out. Signed: the true sign of the WIDTH+1-bit sum,
  // which is the result MSB corrected by the overflow flag.
  always_comb begin
    h = p_hi;
    x = s & p_hi[WIDTH-1];
    if (p_lo[0]) begin
      h = alu_out;
      x = s ? (alu_out[WIDTH-1] ^ alu_ofl) : alu_ofl;
    end
    p_nxt = {x, h, p_lo[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      m       <= '0;
      s       <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          p_hi  <= '0;
          p_lo  <= mplier;
          m     <= mcand;
          s     <= is_signed;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          {p_hi, p_lo} <= p_nxt;
          if (last) begin
            product <= p_nxt;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [15:0] mcand = '0, mplier = '0;
  logic        ready, done, alu_grant, alu_Cin, alu_sign, alu_ofl;
  logic [31:0] product;
  logic [15:0] alu_A, alu_B, alu_out;
  logic [1:0]  alu_op;

  int cmp = 0;
  int err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .mcand(mcand), .mplier(mplier), .ready(ready), .done(done),
    .product(product), .alu_grant(alu_grant), .alu_A(alu_A), .alu_B(alu_B),
    .alu_Cin(alu_Cin), .alu_sign(alu_sign), .alu_op(alu_op),
    .alu_out(alu_out), .alu_ofl(alu_ofl)
  );

  // Shared arithmetic block: 16-bit add with carry-in; Ofl is signed
  // overflow when sign=1, carry-out when sign=0.
  logic [16:0] sum17;
  always_comb begin
    sum17   = {1'b0, alu_A} + {1'b0, alu_B} + {16'b0, alu_Cin};
    alu_out = sum17[15:0];
    alu_ofl = alu_sign ? ((alu_A[15] == alu_B[15]) && (sum17[15] != alu_A[15]))
                       : sum17[16];
  end

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic sg);
    logic signed [31:0] sa, sb;
    logic [31:0] ua, ub;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    ua = {16'b0, a};
    ub = {16'b0, b};
    return sg ? 32'(sa * sb) : ua * ub;
  endfunction

  // One multiply. inj>0 pulses a stray start with other operands in that
  // cycle of the run. Checks latency, ready/grant occupancy, alu_op, the
  // single done pulse and product hold.
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input logic sg,
                        input int inj, input string nm);
    int k, gcnt, rcnt, opbad;
    logic [31:0] exp;
    @(negedge clk);
    mcand = a; mplier = b; is_signed = sg; start = 1'b1;
    exp_q.push_back(ref_mul(a, b, sg));
    @(negedge clk);
    start = 1'b0;
    mcand = 16'hA5A5; mplier = 16'h5A5A; is_signed = ~sg;
    k = 1; gcnt = 0; rcnt = 0; opbad = 0;
    while (k < 40) begin
      start = (k == inj);
      if (!ready) rcnt++;
      if (done) break;
      if (alu_grant) gcnt++;
      if (alu_grant && alu_op !== 2'b00) opbad++;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    exp = exp_q.pop_front();
    cmp++;
    if (!done) begin
      err++; $display("FAIL %s timeout: no done within %0d cycles", nm, k);
      return;
    end
    if (product !== exp) begin
      err++; $display("FAIL %s product: got %h expected %h", nm, product, exp);
    end
    cmp++;
    if (k != 17 || rcnt != 17 || gcnt != 16 || opbad != 0) begin
      err++;
      $display("FAIL %s timing: done@%0d rdy_lo=%0d grant=%0d opbad=%0d expected 17/17/16/0",
               nm, k, rcnt, gcnt, opbad);
    end
    @(negedge clk);
    cmp++;
    if (done !== 1'b0 || ready !== 1'b1 || product !== exp) begin
      err++;
      $display("FAIL %s after: done=%b ready=%b product=%h expected 0/1/%h",
               nm, done, ready, product, exp);
    end
  endtask

  task automatic test_reset();
    cmp++;
    if ({ready, done, alu_grant, product, alu_A, alu_B, alu_Cin, alu_sign, alu_op}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0, 1'b0, 2'b00}) begin
      err++;
      $display("FAIL reset: rdy=%b done=%b gnt=%b prod=%h A=%h B=%h cin=%b sg=%b op=%b expected 1/0/0/0/0/0/0/0/0",
               ready, done, alu_grant, product, alu_A, alu_B, alu_Cin, alu_sign, alu_op);
    end
  endtask

  task automatic test_basic();
    do_mul(16'h0003, 16'h0005, 1'b0, 0, "u3x5");
    cmp++;
    if (product !== 32'h0000000F) begin
      err++; $display("FAIL u3x5 const: got %h expected 0000000f", product);
    end
  endtask

  task automatic test_edges();
    do_mul(16'hFFFF, 16'hFFFF, 1'b0, 0, "uFFFFxFFFF");
    do_mul(16'hFFFF, 16'hFFFF, 1'b1, 0, "sm1xm1");
    do_mul(16'h8000, 16'h8000, 1'b1, 0, "s8000x8000");
    do_mul(16'h7FFF, 16'h8000, 1'b1, 0, "s7FFFx8000");
    do_mul(16'hFFFD, 16'h0007, 1'b1, 0, "sm3x7");
    do_mul(16'h1234, 16'h0000, 1'b0, 0, "u1234x0");
    do_mul(16'h0000, 16'hFFFF, 1'b1, 0, "s0xFFFF");
    for (int i = 0; i < 6; i++)
      do_mul(16'($urandom), 16'($urandom), 1'(i), 0, "rand");
  endtask

  task automatic test_ignore_start();
    do_mul(16'h0102, 16'h0304, 1'b0, 5, "midstart");
    cmp++;
    if (product !== 32'h00030A08) begin
      err++; $display("FAIL midstart const: got %h expected 00030a08", product);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    mcand = 16'h1111; mplier = 16'h2222; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp++;
    if (ready !== 1'b1 || alu_grant !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      err++;
      $display("FAIL rst_midrun: rdy=%b gnt=%b done=%b prod=%h expected 1/0/0/0",
               ready, alu_grant, done, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_mul(16'h0011, 16'h0013, 1'b0, 0, "post_rst");
  endtask

  task automatic test_back_to_back();
    int t, nd, last_t;
    logic [15:0] a, b;
    @(negedge clk);
    a = 16'h00FF; b = 16'h0101;
    mcand = a; mplier = b; is_signed = 1'b0; start = 1'b1;
    exp_q.push_back(ref_mul(a, b, 1'b0));
    nd = 0; last_t = 0;
    for (t = 0; t < 100 && nd < 3; t++) begin
      @(negedge clk);
      if (done) begin
        cmp++;
        if (product !== exp_q[0]) begin
          err++; $display("FAIL b2b product %0d: got %h expected %h", nd, product, exp_q[0]);
        end
        void'(exp_q.pop_front());
        if (nd > 0) begin
          cmp++;
          if (t - last_t != 18) begin
            err++; $display("FAIL b2b spacing: got %0d expected 18", t - last_t);
          end
        end
        last_t = t;
        nd++;
        if (nd < 3) begin
          a = a + 16'h1357; b = b ^ 16'h8421;
          mcand = a; mplier = b; is_signed = nd[0];
          exp_q.push_back(ref_mul(a, b, nd[0]));
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    cmp++;
    if (nd != 3) begin
      err++; $display("FAIL b2b count: got %0d dones expected 3", nd);
    end
    exp_q.delete();
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_edges();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
